// File: rtl/mips_muldiv_if.sv
// Issue/result bundle between a MIPS pipeline and its HI/LO multiply-divide unit.
interface mips_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] s;
  logic [31:0] t;
  logic        mthi;
  logic        mtlo;
  logic [31:0] d;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, s, t, mthi, mtlo, d,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, s, t, mthi, mtlo, d,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One step per cycle for 32 cycles, then one sign-fix cycle that writes HI/LO.
module mips_muldiv (
  input logic          clock,
  input logic          reset,
  mips_muldiv_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]  state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        neg_s_q;
  logic        neg_t_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        in_neg_s;
  logic        in_neg_t;
  logic [31:0] in_mag_s;
  logic [31:0] in_mag_t;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic        div_ge;
  logic [31:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Sign bits are only meaningful for the signed ops; unsigned ops keep raw operands.
  always_comb begin
    in_neg_s = ~bus.op[0] & bus.s[31];
    in_neg_t = ~bus.op[0] & bus.t[31];
    in_mag_s = in_neg_s ? (32'd0 - bus.s) : bus.s;
    in_mag_t = in_neg_t ? (32'd0 - bus.t) : bus.t;
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

  // Divide: acc = {remainder, dividend}; 33-bit trial of shifted remainder vs divisor.
  always_comb begin
    div_ge    = acc_q[63:31] >= {1'b0, opnd_q};
    div_trial = acc_q[62:31] - opnd_q;
    div_next  = div_ge ? {div_trial, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
  end

  always_comb begin
    prod = (neg_s_q ^ neg_t_q) ? (64'd0 - acc_q) : acc_q;
    quo  = (neg_s_q ^ neg_t_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem  = neg_s_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (op_q[1]) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      neg_s_q <= 1'b0;
      neg_t_q <= 1'b0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.mthi) hi_q <= bus.d;
          if (bus.mtlo) lo_q <= bus.d;
          if (bus.start) begin
            op_q    <= bus.op;
            neg_s_q <= in_neg_s;
            neg_t_q <= in_neg_t;
            cnt_q   <= 5'd0;
            state_q <= StRun;
            if (bus.op[1]) begin
              opnd_q <= in_mag_t;
              acc_q  <= {32'd0, in_mag_s};
            end else begin
              opnd_q <= in_mag_s;
              acc_q  <= {32'd0, in_mag_t};
            end
          end
        end
        StRun: begin
          acc_q <= op_q[1] ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: hand-computed HI/LO results, latency, moves and reset.
module tb_mips_muldiv;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mips_muldiv_if bus ();

  mips_muldiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one op and returns at the negedge after the done edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] s,
                        input logic [31:0] t, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit detail, input bit inject,
                        input bit mv_hi);
    bus.start = 1'b1;
    bus.op    = op;
    bus.s     = s;
    bus.t     = t;
    if (mv_hi) begin
      bus.mthi = 1'b1;
      bus.d    = 32'h0000_0055;
    end
    @(negedge clock);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.s     = 32'h0;
    bus.t     = 32'h0;
    if (mv_hi) begin
      model_hi = 32'h0000_0055;
      check_val({tag, " move_hi"}, {32'd0, bus.hi}, {32'd0, model_hi});
    end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      if (detail) begin
        check_val($sformatf("%s busy@%0d", tag, i), {63'd0, bus.busy}, 64'd1);
        check_val($sformatf("%s done@%0d", tag, i), {63'd0, bus.done}, 64'd0);
      end
      if (inject && i == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.s     = 32'd7;
        bus.t     = 32'd9;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.d     = 32'hDEAD_BEEF;
      end
      if (inject && i == 6) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check_val({tag, " hi_held"}, {32'd0, bus.hi}, {32'd0, model_hi});
        check_val({tag, " lo_held"}, {32'd0, bus.lo}, {32'd0, model_lo});
      end
    end
    @(negedge clock);
    check_val({tag, " done"}, {63'd0, bus.done}, 64'd1);
    check_val({tag, " busy_end"}, {63'd0, bus.busy}, 64'd0);
    check_val({tag, " result"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    bit seen_done;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.s     = 32'h0;
    bus.t     = 32'h0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.d     = 32'h0;
    model_hi  = 32'h0;
    model_lo  = 32'h0;
    repeat (2) @(negedge clock);
    check_val("reset busy", {63'd0, bus.busy}, 64'd0);
    check_val("reset done", {63'd0, bus.done}, 64'd0);
    check_val("reset hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check_val("done_pulse", {63'd0, bus.done}, 64'd0);
    check_val("hilo_hold", {bus.hi, bus.lo}, {model_hi, model_lo});

    // Chained back-to-back: each start is driven in the done cycle.
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           1'b0, 1'b0, 1'b0);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
           1'b0, 1'b0, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           1'b0, 1'b0, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'h0000_0001,
           1'b0, 1'b0, 1'b0);
    run_op("div_pos_by0", 2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
           1'b0, 1'b0, 1'b0);
    @(negedge clock);

    run_op("busy_inject", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    run_op("start_mthi", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b1);
    @(negedge clock);

    bus.mthi = 1'b1;
    bus.d    = 32'hCAFE_F00D;
    @(negedge clock);
    bus.mthi = 1'b0;
    check_val("mthi", {bus.hi, bus.lo}, {32'hCAFE_F00D, 32'd12});
    bus.mtlo = 1'b1;
    bus.d    = 32'h1234_5678;
    @(negedge clock);
    bus.mtlo = 1'b0;
    check_val("mtlo", {bus.hi, bus.lo}, {32'hCAFE_F00D, 32'h1234_5678});
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.d    = 32'hA5A5_A5A5;
    @(negedge clock);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check_val("mthi_mtlo", {bus.hi, bus.lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

    // Abort 10 cycles into RUN.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.s     = 32'hFFFF_FFFF;
    bus.t     = 32'd2;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("abort busy", {63'd0, bus.busy}, 64'd0);
    check_val("abort done", {63'd0, bus.done}, 64'd0);
    check_val("abort hilo", {bus.hi, bus.lo}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) seen_done = 1'b1;
    end
    check_val("abort no_done", {63'd0, seen_done}, 64'd0);
    check_val("abort hilo_after", {bus.hi, bus.lo}, 64'd0);

    // Reset wins over start and moves in the same cycle.
    bus.mtlo = 1'b1;
    bus.d    = 32'h0000_0001;
    @(negedge clock);
    bus.mtlo = 1'b0;
    check_val("pre_reset lo", {32'd0, bus.lo}, 64'd1);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.d     = 32'hFFFF_0000;
    @(negedge clock);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check_val("rst_override hilo", {bus.hi, bus.lo}, 64'd0);
    check_val("rst_override busy", {63'd0, bus.busy}, 64'd0);
    repeat (2) @(negedge clock);
    check_val("rst_override idle", {63'd0, bus.busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  issue request; sampled only in IDLE.
REQ-005 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 S, T  in  32 each  operands; S is multiplicand/dividend, T is multiplier/divisor; sampled with start.
REQ-007 mthi, mtlo  in  1 each  direct write of HI/LO from D; sampled only in IDLE.
REQ-008 D  in  32  write data for mthi/mtlo.
REQ-009 busy  out  1  high whenever state is not IDLE; combinational from state.
REQ-010 done  out  1  registered one-cycle pulse marking the HI/LO result update.
REQ-011 hi, lo  out  32 each  registered HI and LO architectural registers.

Function
REQ-012 SHALL have states IDLE, RUN and FIX.
REQ-013 IDLE with start=1: latch op, |S| and |T| (raw values for MULTU/DIVU), and the two sign bits; go to RUN with the 5-bit iteration count at 0.
REQ-014 RUN: perform one radix-2 step per cycle.
- multiply: shift-add into a 64-bit accumulator.
- divide: restoring shift-subtract using a 33-bit trial subtraction.
- increment count; after the step with count=31, go to FIX.
REQ-015 FIX applies sign correction for signed ops only.
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the signs differ; give the remainder the sign of the dividend.
REQ-016 On leaving FIX: write {hi,lo} (product hi:lo; DIV/DIVU hi=remainder, lo=quotient), set done=1 for exactly one cycle, return to IDLE.
REQ-017 Latency: hi/lo update and done=1 appear 33 rising edges after the edge that sampled start; busy=1 for the 32 cycles in between.
REQ-018 start while busy SHALL be ignored; there is no queue and no error output.
REQ-019 mthi/mtlo while busy SHALL be ignored; HI/LO SHALL NOT change before completion.
REQ-020 mthi/mtlo in IDLE SHALL write D to hi/lo at the next edge; both asserted together write D to both.
REQ-021 start together with mthi/mtlo in IDLE: the move takes effect at the next edge, and the operation result later overwrites both hi and lo.
REQ-022 A new start is accepted in the cycle where done=1 (state is IDLE); back-to-back throughput is one op per 34 cycles.
REQ-023 Divide by zero SHALL NOT trap and SHALL follow the algorithm deterministically.
- DIVU x/0: lo=0xFFFFFFFF, hi=x.
- DIV x/0: hi=x; lo=0x00000001 if x<0, otherwise 0xFFFFFFFF.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0; no overflow indication.
REQ-025 MULTU/DIVU SHALL treat operands as unsigned, with no magnitude conversion or FIX correction.
REQ-026 hi/lo SHALL hold their values between operations; done SHALL be 0 except as specified in REQ-016.

Reset
REQ-027 While reset=1 at an edge: state goes to IDLE, hi=0, lo=0, done=0, busy=0, iteration count=0.
REQ-028 Reset SHALL override start, mthi and mtlo in the same cycle.
REQ-029 Reset mid-operation SHALL abort with no done pulse and no partial HI/LO write.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after the start edge, busy high for the 32 cycles before.
REQ-031 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-033 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100; DIV 0xFFFFFFF9 / 0 -> lo=1, hi=0xFFFFFFF9; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Busy-time inputs: start, mthi and mtlo pulsed during RUN -> ignored, and the original result is delivered unchanged.
REQ-035 Reset mid-operation and moves: reset asserted 10 cycles into RUN -> busy=0, hi=lo=0, no done; mtlo with D=0x12345678 in IDLE -> lo=0x12345678 one edge later, hi unchanged.
